alu_exec_queue: RTL



---
 rtl/alu_exec_queue_pkg.sv | 23 ++
 rtl/alu_exec_queue_alu_core.sv | 43 ++++
 rtl/alu_exec_queue.sv | 60 ++++++
 3 files changed

// File: rtl/alu_exec_queue_pkg.sv
// alu_exec_queue_pkg: opcode and ALU/branch op encodings shared by the integer execute stage.
package alu_exec_queue_pkg;
    localparam int ROB_W = 5;
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] BR_EQ  = 4'b0000;
    localparam logic [3:0] BR_NE  = 4'b0001;
    localparam logic [3:0] BR_LT  = 4'b0100;
    localparam logic [3:0] BR_GE  = 4'b0101;
    localparam logic [3:0] BR_LTU = 4'b0110;
    localparam logic [3:0] BR_GEU = 4'b0111;
endpackage

// File: rtl/alu_exec_queue_alu_core.sv
// alu_core: combinational RV32I ALU/branch evaluation; unknown opcodes pass v2 through.
module alu_core import alu_exec_queue_pkg::*; (
    input  logic [6:0]  opc,
    input  logic [3:0]  op,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic [31:0] value
);
    logic [3:0] aop;
    logic [4:0] sh;
    logic       taken;
    always_comb begin
        // immediates reuse funct7[5] only to pick SRAI over SRLI
        aop = (opc == OPC_I && op[2:0] != 3'b101) ? {1'b0, op[2:0]} : op;
        sh = v2[4:0];
        case ({1'b0, op[2:0]})
            BR_EQ:   taken = v1 == v2;
            BR_NE:   taken = v1 != v2;
            BR_LT:   taken = $signed(v1) < $signed(v2);
            BR_GE:   taken = $signed(v1) >= $signed(v2);
            BR_LTU:  taken = v1 < v2;
            BR_GEU:  taken = v1 >= v2;
            default: taken = 1'b0;
        endcase
        value = v2;
        if (opc == OPC_B)
            value = {31'b0, taken};
        else if (opc == OPC_R || opc == OPC_I)
            case (aop)
                ALU_ADD:  value = v1 + v2;
                ALU_SUB:  value = v1 - v2;
                ALU_SLL:  value = v1 << sh;
                ALU_SLT:  value = {31'b0, $signed(v1) < $signed(v2)};
                ALU_SLTU: value = {31'b0, v1 < v2};
                ALU_XOR:  value = v1 ^ v2;
                ALU_SRL:  value = v1 >> sh;
                ALU_SRA:  value = $signed(v1) >>> sh;
                ALU_OR:   value = v1 | v2;
                ALU_AND:  value = v1 & v2;
                default:  value = '0;
            endcase
    end
endmodule

// File: rtl/alu_exec_queue.sv
// alu_exec_queue: integer execute stage with an in-order result FIFO broadcasting on the ALU CDB.
// Define ALU_BYPASS_EN to forward a result to the CDB in its issue cycle when the FIFO is empty.
module alu_exec_queue import alu_exec_queue_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int ROB_W = alu_exec_queue_pkg::ROB_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _alu_ready,
    input  logic [ROB_W-1:0] _alu_rob_id,
    input  logic [6:0]       _alu_type,
    input  logic [3:0]       _alu_op,
    input  logic [31:0]      _alu_v1,
    input  logic [31:0]      _alu_v2,
    output logic             _alu_full,
    input  logic             _cdb_stall,
    output logic             _cdb_ready,
    output logic [ROB_W-1:0] _cdb_rob_id,
    output logic [31:0]      _cdb_value
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [31:0]      result;
    logic             byp, push, pop, busy;
    alu_core u_core (.opc(_alu_type), .op(_alu_op), .v1(_alu_v1), .v2(_alu_v2), .value(result));
`ifdef ALU_BYPASS_EN
    assign byp = rdy_in && !rst_in && !_clear && _alu_ready && !_cdb_stall && count == '0;
`else
    assign byp = 1'b0;
`endif
    assign busy = count != '0;
    assign _alu_full = count == CW'(DEPTH);
    assign push = rdy_in && _alu_ready && !_alu_full && !byp;
    assign pop = rdy_in && busy && !_cdb_stall;
    // entries are never cleared, so gate the head by occupancy
    assign _cdb_ready = busy || byp;
    assign _cdb_rob_id = byp ? _alu_rob_id : busy ? rob_q[head] : '0;
    assign _cdb_value = byp ? result : busy ? val_q[head] : '0;
    always_ff @(posedge clk_in) begin
        if (rst_in || _clear) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                rob_q[tail] <= _alu_rob_id;
                val_q[tail] <= result;
                tail <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
